// File: rtl/bus_cycle_master.sv
// 8088-style bus-cycle master: one request at a time, T1-T2-T3-(TW)*-T4 sequencing.
// Optional wait-state timeout is enabled by defining BUS_CYCLE_MASTER_WAIT_TIMEOUT_EN.
module bus_cycle_master #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_io,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  ALE,
    output logic                  RD,
    output logic                  WR,
    output logic                  IOM,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] AD_OUT,
    output logic                  AD_OE,
    input  logic [DATA_WIDTH-1:0] AD_IN,
    input  logic                  READY
);

    // state | meaning
    // IDLE  | ready for a command
    // T1    | address phase, ALE high
    // T2    | strobe asserted, data bus turned around
    // T3    | strobe held, READY sampled
    // TW    | wait state, READY sampled each cycle
    // T4    | strobe released, response pulse
    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;

    state_t                  state, state_nx;
    logic                    write_q, io_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
    logic                    timeout_hit;

`ifdef BUS_CYCLE_MASTER_WAIT_TIMEOUT_EN
    localparam int WCW = $clog2(MAX_WAIT + 1);
    logic [WCW-1:0] wait_cnt;
    logic           err_q;

    assign timeout_hit = (state == S_TW) && !READY && (wait_cnt == WCW'(MAX_WAIT));
    assign rsp_err     = err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    assign Address   = addr_q;
    assign IOM       = io_q;
    assign rsp_rdata = rdata_q;

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ALE       = 1'b0;
        RD        = 1'b1;
        WR        = 1'b1;
        AD_OE     = 1'b0;
        AD_OUT    = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = S_T1;
            end
            S_T1: begin
                ALE      = 1'b1;
                AD_OE    = 1'b1;
                AD_OUT   = addr_q[DATA_WIDTH-1:0];
                state_nx = S_T2;
            end
            S_T2, S_T3, S_TW: begin
                RD    = write_q;
                WR    = !write_q;
                AD_OE = write_q;
                if (write_q) AD_OUT = wdata_q;
                if (state == S_T2)                 state_nx = S_T3;
                else if (READY || timeout_hit)     state_nx = S_T4;
                else                               state_nx = S_TW;
            end
            S_T4: begin
                rsp_valid = 1'b1;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state   <= S_IDLE;
            write_q <= 1'b0;
            io_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef BUS_CYCLE_MASTER_WAIT_TIMEOUT_EN
            wait_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (state == S_IDLE && req_valid) begin
                write_q <= req_write;
                io_q    <= req_io;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
`ifdef BUS_CYCLE_MASTER_WAIT_TIMEOUT_EN
                err_q   <= 1'b0;
`endif
            end
            if ((state == S_T3 || state == S_TW) && READY && !write_q)
                rdata_q <= AD_IN;
`ifdef BUS_CYCLE_MASTER_WAIT_TIMEOUT_EN
            // Counter saturates at MAX_WAIT; reaching it with READY still low aborts.
            if (state == S_T3 && !READY)
                wait_cnt <= WCW'(1);
            else if (state == S_TW && !READY && wait_cnt != WCW'(MAX_WAIT))
                wait_cnt <= wait_cnt + WCW'(1);
            if (timeout_hit)
                err_q <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_bus_cycle_master.sv
// Self-checking bench for bus_cycle_master: vector table, slave model, response scoreboard.
module tb_bus_cycle_master;
    localparam int AW = 20;
    localparam int DW = 8;
    localparam int MW = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          req_valid, req_ready, req_write, req_io;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          ALE, RD, WR, IOM, AD_OE, READY;
    logic [AW-1:0] Address;
    logic [DW-1:0] AD_OUT, AD_IN;

    always #5 CLK = ~CLK;

    bus_cycle_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM), .Address(Address),
        .AD_OUT(AD_OUT), .AD_OE(AD_OE), .AD_IN(AD_IN), .READY(READY)
    );

    // Slave: byte arrays indexed by the low address bits
    logic [7:0] smem [256];
    logic [7:0] sio  [256];
    assign AD_IN = IOM ? sio[Address[7:0]] : smem[Address[7:0]];
    always @(posedge CLK) begin
        if (RESET === 1'b1 && WR === 1'b0) begin
            if (IOM) sio[Address[7:0]] = AD_OUT;
            else     smem[Address[7:0]] = AD_OUT;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pins();
        return {ALE, RD, WR, AD_OE, rsp_valid, req_ready, IOM};
    endfunction

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;
    rsp_t sbq[$];

    always @(negedge CLK) begin
        rsp_t e;
        if (RESET === 1'b1 && rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    always @(negedge CLK) begin
        if (RESET === 1'b1) begin
            chk("strobe_excl", 32'(!RD && !WR), 32'd0);
            chk("ale_vs_strobe", 32'(ALE && (!RD || !WR)), 32'd0);
        end
    end

    typedef struct {
        logic          write;
        logic          io;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            nwait;
        logic [DW-1:0] exp_rdata;
    } vec_t;
    vec_t vecs[7];

    task automatic run_txn(input logic write, input logic io, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int nwait, input logic stuck,
                           input logic [DW-1:0] exp_rdata, input logic exp_err,
                           input string tag);
        logic [6:0] exp;
        @(negedge CLK);
        req_write = write; req_io = io; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        READY     = 1'b0;
        chk({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
        @(posedge CLK);
        sbq.push_back('{exp_rdata, exp_err});
        for (int c = 1; c <= 5 + nwait; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                req_valid = 1'b0;
                req_addr  = ~addr;
                req_wdata = ~wdata;
                req_write = ~write;
                req_io    = ~io;
            end
            if (c == 1)               exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, io};
            else if (c <= 3 + nwait)  exp = {1'b0, write, !write, write, 1'b0, 1'b0, io};
            else if (c == 4 + nwait)  exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, io};
            else                      exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, io};
            chk($sformatf("%s_pins_c%0d", tag, c), 32'(pins()), 32'(exp));
            chk({tag, "_address"}, 32'(Address), 32'(addr));
            if (c == 1)
                chk({tag, "_ad_addr"}, 32'(AD_OUT), 32'(addr[DW-1:0]));
            else if (write && c <= 3 + nwait)
                chk({tag, "_ad_wdata"}, 32'(AD_OUT), 32'(wdata));
            READY = (c == 3 + nwait) && !stuck;
        end
        READY = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ale1, ale2;
        for (int i = 0; i < 256; i++) begin
            smem[i] = 8'h00;
            sio[i]  = 8'h00;
        end
        smem[8'h3C] = 8'h96;
        smem[8'hFF] = 8'h3D;
        sio[8'h10]  = 8'hA7;

        vecs[0] = '{1'b1, 1'b0, 20'h0003A, 8'h5C, 0, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 20'h00010, 8'h00, 0, 8'hA7};
        vecs[2] = '{1'b0, 1'b0, 20'h0003C, 8'h00, 3, 8'h96};
        vecs[3] = '{1'b0, 1'b0, 20'h0003A, 8'h00, 0, 8'h5C};
        vecs[4] = '{1'b1, 1'b1, 20'h000F3, 8'h11, 1, 8'h00};
        vecs[5] = '{1'b0, 1'b1, 20'h000F3, 8'h00, 2, 8'h11};
        vecs[6] = '{1'b0, 1'b0, 20'hABCFF, 8'h00, 0, 8'h3D};

        RESET = 1'b0; READY = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_pins", 32'(pins()), 32'(7'b0110010));
        chk("reset_address", 32'(Address), 32'd0);
        chk("reset_ad_out", 32'(AD_OUT), 32'd0);
        chk("reset_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset_err", 32'(rsp_err), 32'd0);
        RESET = 1'b1;

        for (int i = 0; i < 7; i++)
            run_txn(vecs[i].write, vecs[i].io, vecs[i].addr, vecs[i].wdata, vecs[i].nwait,
                    1'b0, vecs[i].exp_rdata, 1'b0, $sformatf("vec%0d", i));
        chk("slave_mem_3a", 32'(smem[8'h3A]), 32'h5C);
        chk("slave_io_f3", 32'(sio[8'hF3]), 32'h11);

        // Back-to-back writes with req_valid held high
        @(negedge CLK);
        req_write = 1'b1; req_io = 1'b0; req_addr = 20'h00020; req_wdata = 8'h01;
        req_valid = 1'b1; READY = 1'b1;
        @(posedge CLK);
        sbq.push_back('{8'h00, 1'b0});
        ale1 = -1; ale2 = -1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                req_addr = 20'h00021; req_wdata = 8'h02;
            end
            if (ALE === 1'b1) begin
                if (ale1 < 0) ale1 = c;
                else if (ale2 < 0) ale2 = c;
            end
            chk($sformatf("b2b_req_ready_c%0d", c), 32'(req_ready),
                32'((c == 5 || c >= 10) ? 1 : 0));
            if (c == 5) sbq.push_back('{8'h00, 1'b0});
            if (c == 6) req_valid = 1'b0;
        end
        READY = 1'b0;
        chk("b2b_ale_gap", 32'(ale2 - ale1), 32'd5);
        chk("b2b_mem_20", 32'(smem[8'h20]), 32'h01);
        chk("b2b_mem_21", 32'(smem[8'h21]), 32'h02);

        // Reset asserted during T2 of a write
        @(negedge CLK);
        req_write = 1'b1; req_io = 1'b1; req_addr = 20'h00055; req_wdata = 8'h77;
        req_valid = 1'b1; READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        chk("rst_mid_t2_wr", 32'(WR), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_mid_pins", 32'(pins()), 32'(7'b0110010));
        chk("rst_mid_address", 32'(Address), 32'd0);
        RESET = 1'b1;
        READY = 1'b0;
        repeat (6) @(negedge CLK);

`ifdef BUS_CYCLE_MASTER_WAIT_TIMEOUT_EN
        run_txn(1'b0, 1'b0, 20'h0003C, 8'h00, MW, 1'b1, 8'h00, 1'b1, "timeout");
`else
        @(negedge CLK);
        req_write = 1'b0; req_io = 1'b0; req_addr = 20'h0003C; req_valid = 1'b1;
        READY = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (100) @(negedge CLK);
        chk("no_timeout_rd_low", 32'(RD), 32'd0);
        chk("no_timeout_err", 32'(rsp_err), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        chk("no_timeout_recover_rd", 32'(RD), 32'd1);
`endif

        repeat (3) @(negedge CLK);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
